// File: rtl/sseg_serial_driver.sv
// sseg_serial_driver
//   Segment-map and serial-shift engine for an N-digit 7-segment shift-register chain.
//   A display word is captured on start, mapped into per-digit segment bytes (raw or
//   plane-interleaved), optionally inverted, then shifted out on a divided serial clock
//   and finished with a latch pulse.
//
// Parameters
//   N_DIGITS   number of digits; frame width is 8*N_DIGITS bits
//   HALF_DIV   system clocks per seg_clk half-period
//   MSB_FIRST  1: frame bit W-1 goes out first; 0: bit 0 goes out first
//   SEG_INV    1: every frame bit is inverted (active-low segment boards)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      frame request, accepted only while busy is low
//   mode       0: raw bytes, 1: plane-interleaved map (captured with start)
//   disp_num   display word (captured with start)
//   seg_clk    serial clock to the chain
//   seg_dout   serial data, stable across every seg_clk rising edge
//   seg_latch  storage latch pulse, HALF_DIV clocks after the last bit
//   busy       frame in flight
//   done       one-cycle completion pulse (last latch cycle)

module sseg_serial_driver #(
    parameter int unsigned N_DIGITS  = 8,
    parameter int unsigned HALF_DIV  = 2,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          SEG_INV   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [8*N_DIGITS-1:0] disp_num,
    output logic                  seg_clk,
    output logic                  seg_dout,
    output logic                  seg_latch,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned N      = N_DIGITS;
    localparam int unsigned FrameW = 8 * N_DIGITS;
    localparam int unsigned HcW    = $clog2(HALF_DIV + 1);
    localparam int unsigned BcW    = $clog2(FrameW + 1);

    localparam logic [HcW-1:0] HcLast = HcW'(HALF_DIV - 1);
    localparam logic [BcW-1:0] BcLast = BcW'(FrameW - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

    state_e              state_q, state_d;
    logic [FrameW-1:0]   frame_q, frame_d;
    logic [HcW-1:0]      half_cnt_q, half_cnt_d;
    logic [BcW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                seg_clk_q, seg_clk_d;

    logic [FrameW-1:0]   map_planes;
    logic [FrameW-1:0]   frame_in;
    logic                half_last;
    logic                accept;

    // Plane-interleaved map: digit d takes its segments from the bit planes of the
    // display word, with digit order reversed (r = N-1-d).
    for (genvar d = 0; d < N; d++) begin : g_map
        localparam int unsigned R = N - 1 - d;
        assign map_planes[8*d +: 8] = {
            disp_num[5*N + 2*R],
            disp_num[7*N + R],
            disp_num[N + 2*R + 1],
            disp_num[3*N + 2*R + 1],
            disp_num[5*N + 2*R + 1],
            disp_num[3*N + 2*R],
            disp_num[N + 2*R],
            disp_num[R]
        };
    end

    assign frame_in = (mode ? map_planes : disp_num) ^ {FrameW{SEG_INV}};

    assign half_last = (half_cnt_q == HcLast);

    // The final latch cycle doubles as the done cycle, so a new start is taken on the
    // same edge that ends the frame and back-to-back frames leave no gap.
    assign done      = (state_q == StLatch) && half_last;
    assign busy      = (state_q != StIdle) && !done;
    assign accept    = start && !busy;
    assign seg_latch = (state_q == StLatch);
    assign seg_clk   = seg_clk_q;

    // The outgoing bit always sits at the shift end; it is left unshifted after the
    // last bit so seg_dout holds its value while idle.
    assign seg_dout  = MSB_FIRST ? frame_q[FrameW-1] : frame_q[0];

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        seg_clk_d  = seg_clk_q;

        unique case (state_q)
            StIdle: begin
            end
            StShift: begin
                if (half_last) begin
                    half_cnt_d = '0;
                    if (!seg_clk_q) begin
                        seg_clk_d = 1'b1;
                    end else begin
                        seg_clk_d = 1'b0;
                        if (bit_cnt_q == BcLast) begin
                            bit_cnt_d = '0;
                            state_d   = StLatch;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            frame_d   = MSB_FIRST ? {frame_q[FrameW-2:0], 1'b0}
                                                  : {1'b0, frame_q[FrameW-1:1]};
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            StLatch: begin
                if (half_last) begin
                    half_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            state_d    = StShift;
            frame_d    = frame_in;
            half_cnt_d = '0;
            bit_cnt_d  = '0;
            seg_clk_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            seg_clk_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            seg_clk_q  <= seg_clk_d;
        end
    end

endmodule

// File: tb/tb_sseg_serial_driver.sv
module tb_sseg_serial_driver;

    localparam int N     = 8;
    localparam int W     = 8 * N;
    localparam int H     = 2;
    localparam int FRAME = 2 * H * W + H;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;

    logic         start_a = 1'b0;
    logic         mode_a  = 1'b0;
    logic [W-1:0] disp_a  = '0;
    logic         clk_a, dout_a, latch_a, busy_a, done_a;

    logic         start_b = 1'b0;
    logic         mode_b  = 1'b0;
    logic [W-1:0] disp_b  = '0;
    logic         clk_b, dout_b, latch_b, busy_b, done_b;

    sseg_serial_driver #(
        .N_DIGITS (N),
        .HALF_DIV (H),
        .MSB_FIRST(1'b1),
        .SEG_INV  (1'b0)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .mode     (mode_a),
        .disp_num (disp_a),
        .seg_clk  (clk_a),
        .seg_dout (dout_a),
        .seg_latch(latch_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    sseg_serial_driver #(
        .N_DIGITS (N),
        .HALF_DIV (H),
        .MSB_FIRST(1'b0),
        .SEG_INV  (1'b1)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .mode     (mode_b),
        .disp_num (disp_b),
        .seg_clk  (clk_b),
        .seg_dout (dout_b),
        .seg_latch(latch_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation mux: sel=0 watches dut_a (MSB first, plain), sel=1 dut_b (LSB first, inverted).
    logic sel = 1'b0;
    logic o_clk, o_dout, o_latch, o_busy, o_done;
    assign o_clk   = sel ? clk_b   : clk_a;
    assign o_dout  = sel ? dout_b  : dout_a;
    assign o_latch = sel ? latch_b : latch_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;

    logic [W-1:0] cap_vec;
    int           cap_edges, cap_latch, cap_glitch, cap_busy_bad, cap_first_one;
    int           cap_done_t[$];

    // Reference map built straight from the digit/plane rule.
    function automatic logic [W-1:0] ref_frame(input logic [W-1:0] d, input logic m,
                                               input bit inv);
        logic [W-1:0] f;
        int r;
        f = d;
        if (m) begin
            for (int dg = 0; dg < N; dg++) begin
                r = N - 1 - dg;
                f[8*dg+0] = d[r];
                f[8*dg+1] = d[N + 2*r];
                f[8*dg+2] = d[3*N + 2*r];
                f[8*dg+3] = d[5*N + 2*r + 1];
                f[8*dg+4] = d[3*N + 2*r + 1];
                f[8*dg+5] = d[N + 2*r + 1];
                f[8*dg+6] = d[7*N + r];
                f[8*dg+7] = d[5*N + 2*r];
            end
        end
        if (inv) f = ~f;
        return f;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // Issues one start and records what the selected DUT does for `window` clocks.
    // t counts negedges after the cycle in which start was presented; pulse_t adds a
    // one-cycle start pulse at that offset (negative for none).
    task automatic capture(input int window, input int pulse_t);
        logic pc, pd;
        bit   msb;
        msb           = !sel;
        cap_vec       = '0;
        cap_edges     = 0;
        cap_latch     = 0;
        cap_glitch    = 0;
        cap_busy_bad  = 0;
        cap_first_one = -1;
        cap_done_t.delete();
        @(negedge clk);
        set_start(1'b1);
        pc = o_clk;
        pd = o_dout;
        for (int t = 1; t <= window; t++) begin
            @(negedge clk);
            if (t == 1 || t == pulse_t + 1) set_start(1'b0);
            if (t == pulse_t) set_start(1'b1);
            if (!pc && o_clk) begin
                if (cap_edges < W) cap_vec[msb ? W - 1 - cap_edges : cap_edges] = o_dout;
                if (o_dout && cap_first_one < 0) cap_first_one = cap_edges;
                cap_edges++;
            end
            if (o_clk && o_dout !== pd) cap_glitch++;
            if (o_latch) cap_latch++;
            if (o_done) begin
                cap_done_t.push_back(t);
                if (o_busy) cap_busy_bad++;
            end else if (t < FRAME && !o_busy) begin
                cap_busy_bad++;
            end
            pc = o_clk;
            pd = o_dout;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({clk_a, dout_a, latch_a, busy_a, done_a, clk_b, dout_b, latch_b, busy_b, done_b}
            !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 0000000000",
                     {clk_a, dout_a, latch_a, busy_a, done_a,
                      clk_b, dout_b, latch_b, busy_b, done_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({clk_a, dout_a, latch_a, busy_a, done_a, clk_b, dout_b, latch_b, busy_b,
                 done_b} !== 10'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: %0d cycles with outputs active, expected 0", bad);
        end
    endtask

    task automatic test_single_bits();
        logic [W-1:0] exp_f;
        sel    = 1'b0;
        mode_a = 1'b0;
        disp_a = 64'h8000_0000_0000_0001;
        exp_f  = ref_frame(disp_a, 1'b0, 1'b0);
        capture(FRAME + 10, -1);
        n_checks++;
        if (cap_edges != W) begin
            n_fail++;
            $display("FAIL edge_count: got %0d, expected %0d", cap_edges, W);
        end
        n_checks++;
        if (cap_vec !== exp_f) begin
            n_fail++;
            $display("FAIL raw_bits: got %h, expected %h", cap_vec, exp_f);
        end
        n_checks++;
        if (cap_latch != H) begin
            n_fail++;
            $display("FAIL latch_width: got %0d, expected %0d", cap_latch, H);
        end
        n_checks++;
        if (cap_done_t.size() != 1 || cap_done_t[0] != FRAME) begin
            n_fail++;
            $display("FAIL done_timing: got %0d pulses first at %0d, expected 1 at %0d",
                     cap_done_t.size(), cap_done_t.size() > 0 ? cap_done_t[0] : -1, FRAME);
        end
        n_checks++;
        if (cap_busy_bad != 0) begin
            n_fail++;
            $display("FAIL busy_window: got %0d bad cycles, expected 0", cap_busy_bad);
        end
        n_checks++;
        if (cap_glitch != 0) begin
            n_fail++;
            $display("FAIL dout_stable: got %0d changes while seg_clk high, expected 0",
                     cap_glitch);
        end
    endtask

    task automatic test_plane_map();
        sel    = 1'b0;
        mode_a = 1'b1;
        disp_a = '0;
        disp_a[63] = 1'b1;
        capture(FRAME + 4, -1);
        mode_a = 1'b0;
        n_checks++;
        if (cap_vec !== ref_frame(disp_a, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL plane_bits: got %h, expected %h", cap_vec,
                     ref_frame(disp_a, 1'b1, 1'b0));
        end
        n_checks++;
        if (cap_first_one != 57 || $countones(cap_vec) != 1) begin
            n_fail++;
            $display("FAIL plane_position: got first one at edge %0d (%0d ones), expected 57 (1)",
                     cap_first_one, $countones(cap_vec));
        end
    endtask

    task automatic test_inverted();
        logic [W-1:0] ones;
        ones   = '1;
        sel    = 1'b1;
        mode_b = 1'b0;
        disp_b = '0;
        capture(FRAME + 4, -1);
        n_checks++;
        if (cap_edges != W || cap_vec !== ones) begin
            n_fail++;
            $display("FAIL inverted_zero: got %0d edges data %h, expected %0d edges all ones",
                     cap_edges, cap_vec, W);
        end
        n_checks++;
        if (cap_done_t.size() != 1 || cap_done_t[0] != FRAME) begin
            n_fail++;
            $display("FAIL inverted_done: got %0d pulses, expected 1 at %0d",
                     cap_done_t.size(), FRAME);
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic         m;
        for (int i = 0; i < 8; i++) begin
            sel = (i % 2) == 1;
            d   = {$urandom, $urandom};
            m   = 1'($urandom_range(0, 1));
            if (sel) begin disp_b = d; mode_b = m; end
            else begin disp_a = d; mode_a = m; end
            capture(FRAME + 4, -1);
            n_checks++;
            if (cap_vec !== ref_frame(d, m, sel)) begin
                n_fail++;
                $display("FAIL random_frame[%0d]: got %h, expected %h (mode %0d dut %0d)",
                         i, cap_vec, ref_frame(d, m, sel), m, sel);
            end
            n_checks++;
            if (cap_edges != W || cap_done_t.size() != 1 || cap_glitch != 0) begin
                n_fail++;
                $display("FAIL random_shape[%0d]: got %0d edges %0d dones %0d glitches, expected %0d 1 0",
                         i, cap_edges, cap_done_t.size(), cap_glitch, W);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_ignored_start();
        sel    = 1'b0;
        mode_a = 1'b0;
        disp_a = {$urandom, $urandom};
        capture(FRAME + 300, 50);
        n_checks++;
        if (cap_done_t.size() != 1 || cap_latch != H) begin
            n_fail++;
            $display("FAIL ignored_start: got %0d dones %0d latch cycles, expected 1 and %0d",
                     cap_done_t.size(), cap_latch, H);
        end
        n_checks++;
        if (cap_vec !== disp_a) begin
            n_fail++;
            $display("FAIL ignored_start_data: got %h, expected %h", cap_vec, disp_a);
        end
    endtask

    task automatic test_back_to_back();
        int dones[$];
        sel = 1'b0;
        mode_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        for (int t = 1; t <= 3 * FRAME + 20; t++) begin
            @(negedge clk);
            if (done_a) begin
                dones.push_back(t);
                disp_a = {$urandom, $urandom};
            end
            if (t == 3 * FRAME) start_a = 1'b0;
        end
        n_checks++;
        if (dones.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d dones, expected 3", dones.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (dones[k] != (k + 1) * FRAME) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d, expected %0d",
                             k, dones[k], (k + 1) * FRAME);
                end
            end
        end
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy %b, expected 0", busy_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   edges, guard, bad;
        logic pc;
        sel    = 1'b0;
        mode_a = 1'b0;
        disp_a = {$urandom, $urandom};
        @(negedge clk);
        start_a = 1'b1;
        pc      = clk_a;
        edges   = 0;
        guard   = 0;
        while (edges < 20 && guard < 300) begin
            @(negedge clk);
            start_a = 1'b0;
            if (!pc && clk_a) edges++;
            pc = clk_a;
            guard++;
        end
        n_checks++;
        if (edges != 20) begin
            n_fail++;
            $display("FAIL midreset_reach: got %0d edges, expected 20", edges);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({clk_a, dout_a, latch_a, busy_a, done_a} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b, expected 00000",
                     {clk_a, dout_a, latch_a, busy_a, done_a});
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (latch_a || done_a) bad++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (latch_a || done_a || busy_a) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_no_latch: got %0d active cycles, expected 0", bad);
        end
        disp_a = {$urandom, $urandom};
        capture(FRAME + 4, -1);
        n_checks++;
        if (cap_vec !== disp_a || cap_done_t.size() != 1 || cap_latch != H) begin
            n_fail++;
            $display("FAIL midreset_recover: got %h (%0d dones, %0d latch), expected %h (1, %0d)",
                     cap_vec, cap_done_t.size(), cap_latch, disp_a, H);
        end
    endtask

    initial begin
        test_reset();
        test_single_bits();
        test_plane_map();
        test_inverted();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
